// File: rtl/sort_arb_pkg.sv
// Shared types for the sort-engine arbiter: FSM states, key width and the
// record layout used on every key-array port.
package sort_arb_pkg;

   localparam int KEY_W      = 8;
   localparam int REC_FIELDS = 3;

   typedef logic [REC_FIELDS-1:0][KEY_W-1:0] key_rec_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/sort_engine_arbiter_rr_pick.sv
// Rotate-priority encoder: the first set request at or after rr_ptr
// (wrapping) wins; returns it one-hot and as an index.
module rr_pick #(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
   output logic [NUM_REQ-1:0]         win_onehot,
   output logic [$clog2(NUM_REQ)-1:0] win_idx,
   output logic                       win_valid
);

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [IDX_W-1:0] cand;

   always_comb begin
      win_onehot = '0;
      win_idx    = '0;
      win_valid  = 1'b0;
      cand       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
         if (!win_valid && req[cand]) begin
            win_valid        = 1'b1;
            win_idx          = cand;
            win_onehot[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sort_engine_arbiter.sv
// Round-robin arbiter sharing one merge-sort engine between NUM_REQ
// requesters, with a watchdog that aborts jobs the engine never finishes.
module sort_engine_arbiter
   import sort_arb_pkg::*;
#(
   parameter int STRING_LEN  = 32,
   parameter int VAR_LEN     = 3,
   parameter int NUM_REQ     = 2,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                                     clk,
   input  logic                                     rst,
   // Handshake: req is a level held until the matching ack pulse; grant is
   // one-hot while a job is in flight; ack pulses one cycle, qualified by err.
   input  logic     [NUM_REQ-1:0]                   req,
   input  key_rec_t [NUM_REQ-1:0][STRING_LEN-1:0]   req_data,
   input  logic     [NUM_REQ-1:0]                   req_sort_num,
   output logic     [NUM_REQ-1:0]                   grant,
   output logic     [NUM_REQ-1:0]                   ack,
   output logic                                     err,
   output key_rec_t [STRING_LEN-1:0]                rsp_data,
   output logic                                     busy,
   output logic                                     eng_start,
   output logic                                     eng_sort_num,
   output key_rec_t [STRING_LEN-1:0]                eng_data_in,
   input  logic                                     eng_sorted,
   input  key_rec_t [STRING_LEN-1:0]                eng_data_out,
   output arb_state_t                               dbg_state
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYC);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

   if (VAR_LEN != REC_FIELDS) begin : g_rec_fields_mismatch
      $error("sort_engine_arbiter: VAR_LEN differs from sort_arb_pkg::REC_FIELDS");
   end

   arb_state_t                 state, state_nxt;
   logic [IDX_W-1:0]           rr_ptr, rr_ptr_nxt, g_idx, g_idx_nxt;
   logic [WD_W-1:0]            wdog, wdog_nxt;
   logic [NUM_REQ-1:0]         grant_nxt, ack_nxt, win_onehot;
   logic [IDX_W-1:0]           win_idx;
   logic                       win_valid;
   logic                       err_nxt, eng_start_nxt, eng_sort_num_nxt;
   key_rec_t [STRING_LEN-1:0]  rsp_nxt, eng_in_nxt;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
      .req        (req),
      .rr_ptr     (rr_ptr),
      .win_onehot (win_onehot),
      .win_idx    (win_idx),
      .win_valid  (win_valid)
   );

   always_comb begin
      state_nxt        = state;
      rr_ptr_nxt       = rr_ptr;
      g_idx_nxt        = g_idx;
      wdog_nxt         = wdog;
      grant_nxt        = grant;
      ack_nxt          = '0;
      err_nxt          = err;
      eng_start_nxt    = 1'b0;
      eng_sort_num_nxt = eng_sort_num;
      rsp_nxt          = rsp_data;
      eng_in_nxt       = eng_data_in;
      case (state)
         ST_IDLE: begin
            if (win_valid) begin
               g_idx_nxt        = win_idx;
               grant_nxt        = win_onehot;
               eng_in_nxt       = req_data[win_idx];
               eng_sort_num_nxt = req_sort_num[win_idx];
               eng_start_nxt    = 1'b1;
               state_nxt        = ST_START;
            end
         end
         ST_START: begin
            wdog_nxt  = '0;
            state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (wdog != WD_MAX) wdog_nxt = wdog + 1'b1;
            // A completion in the last watchdog cycle still counts as success.
            if (eng_sorted) begin
               rsp_nxt   = eng_data_out;
               err_nxt   = 1'b0;
               ack_nxt   = grant;
               state_nxt = ST_DONE;
            end else if (wdog == WD_LAST) begin
               err_nxt   = 1'b1;
               ack_nxt   = grant;
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            grant_nxt  = '0;
            rr_ptr_nxt = (g_idx == IDX_W'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
            state_nxt  = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         rr_ptr       <= '0;
         g_idx        <= '0;
         wdog         <= '0;
         grant        <= '0;
         ack          <= '0;
         err          <= 1'b0;
         busy         <= 1'b0;
         eng_start    <= 1'b0;
         eng_sort_num <= 1'b0;
         rsp_data     <= '0;
         eng_data_in  <= '0;
      end else begin
         state        <= state_nxt;
         rr_ptr       <= rr_ptr_nxt;
         g_idx        <= g_idx_nxt;
         wdog         <= wdog_nxt;
         grant        <= grant_nxt;
         ack          <= ack_nxt;
         err          <= err_nxt;
         busy         <= (state_nxt != ST_IDLE);
         eng_start    <= eng_start_nxt;
         eng_sort_num <= eng_sort_num_nxt;
         rsp_data     <= rsp_nxt;
         eng_data_in  <= eng_in_nxt;
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_sort_engine_arbiter.sv
// Bench for sort_engine_arbiter: a behavioural engine stub plus a job-level
// model (round-robin pointer, expected response queue, cycle budgets).
module tb_sort_engine_arbiter;
   import sort_arb_pkg::*;

   localparam int NR = 2;
   localparam int SL = 8;
   localparam int VL = REC_FIELDS;
   localparam int T  = 16;
   localparam int DW = SL * VL * KEY_W;

   typedef key_rec_t [SL-1:0] arr_t;

   logic                        clk = 1'b0;
   logic                        rst = 1'b1;
   logic [NR-1:0]               req = '0;
   key_rec_t [NR-1:0][SL-1:0]   req_data = '0;
   logic [NR-1:0]               req_sort_num = '0;
   logic [NR-1:0]               grant, ack;
   logic                        err, busy, eng_start, eng_sort_num, eng_sorted;
   arr_t                        rsp_data, eng_data_in;
   arr_t                        eng_data_out = '0;
   arb_state_t                  dbg_state;

   logic stub_sorted  = 1'b0;
   logic force_sorted = 1'b0;
   int   stub_lat     = 0;
   int   stub_cnt     = 0;
   arr_t stub_in      = '0;
   logic stub_sel     = 1'b0;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          ptr_m    = 0;
   arr_t        last_rsp_m = '0;
   int          ack_cnt [NR] = '{default: 0};
   logic [DW-1:0] exp_q [$];

   sort_engine_arbiter #(
      .STRING_LEN  (SL),
      .VAR_LEN     (VL),
      .NUM_REQ     (NR),
      .TIMEOUT_CYC (T)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .req_data     (req_data),
      .req_sort_num (req_sort_num),
      .grant        (grant),
      .ack          (ack),
      .err          (err),
      .rsp_data     (rsp_data),
      .busy         (busy),
      .eng_start    (eng_start),
      .eng_sort_num (eng_sort_num),
      .eng_data_in  (eng_data_in),
      .eng_sorted   (eng_sorted),
      .eng_data_out (eng_data_out),
      .dbg_state    (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- engine reference behaviour ----------------
   function automatic arr_t sort_recs(input arr_t a, input logic sel);
      arr_t     r;
      key_rec_t t;
      int       f;
      r = a;
      f = int'(sel);
      for (int i = 1; i < SL; i++)
         for (int j = i; j > 0; j--)
            if (r[j-1][f] > r[j][f]) begin
               t      = r[j];
               r[j]   = r[j-1];
               r[j-1] = t;
            end
      return r;
   endfunction

   always @(negedge clk) begin
      stub_sorted = 1'b0;
      if (rst) begin
         stub_cnt = 0;
      end else begin
         if (stub_cnt > 0) begin
            stub_cnt--;
            if (stub_cnt == 0) begin
               stub_sorted  = 1'b1;
               eng_data_out = sort_recs(stub_in, stub_sel);
            end
         end
         if (eng_start) begin
            stub_in  = eng_data_in;
            stub_sel = eng_sort_num;
            stub_cnt = stub_lat;
         end
      end
   end

   assign eng_sorted = stub_sorted | force_sorted;

   // ---------------- scoreboard / model ----------------
   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int pick(input logic [NR-1:0] r, input int p);
      for (int k = 0; k < NR; k++)
         if (r[(p + k) % NR]) return (p + k) % NR;
      return 0;
   endfunction

   // ---------------- drivers ----------------
   task automatic scramble();
      logic [31:0] rv;
      for (int r = 0; r < NR; r++)
         for (int s = 0; s < SL; s++) begin
            rv = $urandom();
            req_data[r][s] = rv[VL*KEY_W-1:0];
         end
      rv = $urandom();
      req_sort_num = rv[NR-1:0];
   endtask

   // Called in an IDLE cycle with req already presented; returns in the
   // IDLE cycle after DONE.
   task automatic run_job(input int lat, input bit spur, input int drop_at, input bit keep_req);
      int            w, n, extra, exp_n;
      arr_t          snap;
      logic          snap_sel;
      bit            exp_err;
      logic [DW-1:0] exp_rsp;
      check("idle_busy", DW'(busy), '0);
      check("idle_grant", DW'(grant), '0);
      w        = pick(req, ptr_m);
      snap     = req_data[w];
      snap_sel = req_sort_num[w];
      stub_lat = lat;
      exp_err  = (lat < 1) || (lat > T);
      exp_n    = exp_err ? T + 2 : lat + 2;
      exp_q.push_back(exp_err ? DW'(last_rsp_m) : DW'(sort_recs(snap, snap_sel)));
      if (spur) force_sorted = 1'b1;
      tick();
      check("start_grant", DW'(grant), DW'(1 << w));
      check("start_pulse", DW'(eng_start), DW'(1));
      check("start_data", DW'(eng_data_in), DW'(snap));
      check("start_sel", DW'(eng_sort_num), DW'(snap_sel));
      scramble();
      tick();
      force_sorted = 1'b0;
      n     = 2;
      extra = 0;
      while (ack == '0 && n < exp_n + 8) begin
         if (eng_start) extra++;
         if (n == drop_at) req[w] = 1'b0;
         scramble();
         tick();
         n++;
      end
      exp_rsp = exp_q.pop_front();
      check("ack_cycle", DW'(n), DW'(exp_n));
      check("ack_vec", DW'(ack), DW'(1 << w));
      check("ack_err", DW'(err), DW'(exp_err));
      check("rsp_data", DW'(rsp_data), exp_rsp);
      check("data_held", DW'(eng_data_in), DW'(snap));
      check("start_once", DW'(extra), '0);
      for (int k = 0; k < NR; k++) if (ack[k]) ack_cnt[k]++;
      if (!exp_err) last_rsp_m = sort_recs(snap, snap_sel);
      ptr_m  = (w + 1) % NR;
      req[w] = keep_req;
      tick();
      check("ack_single", DW'(ack), '0);
   endtask

   task automatic reset_mid_wait();
      int w;
      int stray;
      stray        = 0;
      req          = 2'b10;
      req_sort_num = 2'b11;
      stub_lat     = 6;
      w = pick(req, ptr_m);
      tick();
      check("rmw_grant", DW'(grant), DW'(1 << w));
      repeat (3) tick();
      check("rmw_busy", DW'(busy), DW'(1));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req = '0;
      check("rst_grant", DW'(grant), '0);
      check("rst_ack", DW'(ack), '0);
      check("rst_err", DW'(err), '0);
      check("rst_busy", DW'(busy), '0);
      check("rst_start", DW'(eng_start), '0);
      check("rst_sel", DW'(eng_sort_num), '0);
      check("rst_rsp", DW'(rsp_data), '0);
      check("rst_data_in", DW'(eng_data_in), '0);
      check("rst_state", DW'(dbg_state), DW'(ST_IDLE));
      exp_q.delete();
      ptr_m      = 0;
      last_rsp_m = '0;
      repeat (T + 4) begin
         tick();
         if (ack != '0) stray++;
      end
      check("rmw_no_ack", DW'(stray), '0);
   endtask

   // ---------------- stimulus + report ----------------
   initial begin
      int c0, c1, lat, drop;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      check("reset_grant", DW'(grant), '0);
      check("reset_ack", DW'(ack), '0);
      check("reset_err", DW'(err), '0);
      check("reset_busy", DW'(busy), '0);
      check("reset_start", DW'(eng_start), '0);
      check("reset_sel", DW'(eng_sort_num), '0);
      check("reset_rsp", DW'(rsp_data), '0);
      check("reset_data_in", DW'(eng_data_in), '0);
      scramble();

      req = 2'b11;
      run_job(10, 1'b0, -1, 1'b0);
      run_job(10, 1'b0, -1, 1'b0);

      req = 2'b01;
      run_job(10, 1'b0, -1, 1'b0);

      c0  = ack_cnt[0];
      c1  = ack_cnt[1];
      req = 2'b11;
      repeat (4) run_job(7, 1'b0, -1, 1'b1);
      check("cont_acks0", DW'(ack_cnt[0] - c0), DW'(2));
      check("cont_acks1", DW'(ack_cnt[1] - c1), DW'(2));

      req = 2'b01;
      run_job(0, 1'b0, -1, 1'b0);
      req = 2'b10;
      run_job(T, 1'b0, -1, 1'b0);
      req = 2'b01;
      run_job(T + 1, 1'b0, -1, 1'b0);

      reset_mid_wait();
      req = 2'b01;
      run_job(5, 1'b0, -1, 1'b0);

      req = 2'b10;
      run_job(6, 1'b1, 4, 1'b0);

      for (int j = 0; j < 24; j++) begin
         lat  = int'($urandom_range(0, T + 2));
         drop = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 10)) : -1;
         req  = NR'($urandom_range(1, (1 << NR) - 1));
         run_job(lat, 1'($urandom_range(0, 1)), drop, 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
